c_dcache_stage: RTL and testbench
=================================

// Module: c_dcache_stage
// PURPOSE
// - Memory (C) stage of the 5-stage RISC-V pipeline: consumes the A->C register (ac_*, ALU_result) and produces the C->W register (cw_*).
// - Holds a direct-mapped, write-through, no-write-allocate data cache with a blocking word-serial refill port.
// - Generates dcache_stall, which freezes all upstream stages while a miss or store is in progress.
// PARAMETERS
// - LINES       16  cache lines, power of 2
// - LINE_WORDS  4   32-bit words per line, power of 2
// PORTS
// - clock         in   1   single clock, rising edge
// - reset         in   1   asynchronous, active-low
// - icache_stall  in   1   fetch stall; C->W register holds
// - mul_stall     in   1   A stage is replaying the same ac_* contents
// - ac_pc         in   32  pc of instruction in C
// - ac_write_sel  in   5   destination register
// - ac_is_load/ac_is_store/ac_is_wb  in  1 each
// - ALU_result    in   32  byte address (load/store) or result to write back
// - ac_data2      in   32  store data
// - cw_pc         out  32  registered
// - cw_is_wb      out  1   registered
// - cw_write_sel  out  5   registered
// - cw_result     out  32  registered: load data or ALU_result
// - dcache_stall  out  1   combinational
// - mem_req, mem_we  out  1   memory request / write enable
// - mem_addr      out  32  word-aligned byte address
// - mem_wdata     out  32  store data
// - mem_rdata     in   32  read data, valid with mem_ack
// - mem_ack       in   1   one-cycle completion pulse per word
// BEHAVIOUR
// - Reset (reset=0, async): all valid bits 0, FSM IDLE, consumed=0, mem_req=0, every cw_* = 0.
// - Address split: bits[1:0] ignored; word = [2 +: log2(LINE_WORDS)]; index = next log2(LINES) bits; tag = remaining upper bits.
// - FSM states: IDLE, REFILL, WRITE.
// - Load hit in IDLE: no stall; cw_result = cached word at the next edge (1-cycle latency).
// - Load miss: IDLE->REFILL with dcache_stall=1. Issues LINE_WORDS sequential requests, words 0..N-1. mem_req stays high and mem_addr advances the cycle after each ack. Each word is written to data RAM. tag and valid are set only on the last ack. Then ->IDLE, the access is re-looked-up and hits, and the stall drops in that cycle.
// - Store: IDLE->WRITE, dcache_stall=1. mem_we=1, addr/wdata held until mem_ack. On a tag hit the cached word is updated on entry; on a miss no allocate. On ack ->IDLE, the instruction retires, and the stall drops.
// - Non-memory op: cw_result = ALU_result, no stall.
// - mem_req/mem_we/mem_addr/mem_wdata are stable from assert until mem_ack. mem_req=0 in IDLE.
// - C->W register updates only when !dcache_stall && !icache_stall. While stalled it holds; the FSM keeps running regardless of icache_stall.
// - mul_stall replay: once an instruction retires while mul_stall=1, set consumed=1. While consumed=1, treat ac_* as a bubble (no access, cw_is_wb=0 written). Clear consumed when mul_stall=0.
// - Reset mid-REFILL/WRITE: abandoned immediately, mem_req=0; the partially filled line stays invalid.
// - Loads with ac_is_load && ac_is_store both set are illegal; store takes priority.
// CONFIGURATION
// - DCACHE_STATS_EN defined: adds outputs stat_hits, stat_misses (32 bits each, wrap at 2^32, reset 0). Each counts once per retired load hit/miss; a refill counts as one miss, not also as a hit.
// - DCACHE_STATS_EN undefined: no counters, no ports; behaviour is otherwise identical.
// STRUCTURE
// - Shared package c_pkg: FSM state enum, index/tag/offset width localparams derived from LINES and LINE_WORDS.
// - One sub-module dcache_array: tag/valid/data storage with 1 read port, 1 write port, and a synchronous-clear-free async valid reset.
// - The top holds the FSM, refill counter, consumed flag and C->W register.
// TESTING
// - Reset then load x100 (mem[x100]=xAA) -> 4 reads x100..x10C, stall for 4 acks + 1 cycle, cw_result=xAA, cw_is_wb=1.
// - Second load x104 right after -> no stall, cw_result=mem[x104] next edge, stat_hits=1, stat_misses=1 (STATS_EN).
// - Store x108 data x55 on a resident line -> single write, mem_we=1, stall until ack; a following load x108 hits and returns x55.
// - Store to non-resident x2000 -> write-through only; a load x2000 then misses (no allocate).
// - mul_stall=1 for 3 cycles holding one store -> exactly one mem write, cw_is_wb=0 on the replay cycles.
// - reset=0 asserted mid-refill after 2 acks -> mem_req=0 at once; after release, a load to the same line misses again.

Source files
------------

// File: rtl/c_pkg.sv
// c_pkg: shared cache geometry and stage FSM encoding for c_dcache_stage.
package c_pkg;

    localparam int unsigned LINES      = 16;
    localparam int unsigned LINE_WORDS = 4;

    // Byte address split: [1:0] byte, then word-in-line, then index, then tag.
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } dc_state_e;

endpackage

// File: rtl/c_dcache_stage_array.sv
// dcache_array: tag/valid/data storage for the direct-mapped data cache.
// One asynchronous read port, one write port for data words, one tag/valid fill port.
// Only the valid bits are reset; tags and data are don't-care while invalid.
module dcache_array
    import c_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_word,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_word,
    input  logic [31:0]      wr_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] tag_wdata
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [31:0]      data_q [LINES][LINE_WORDS];
    logic [31:0]      data_d [LINES][LINE_WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx][rd_word];

    // Next-state of tag/valid: a completed fill marks the line resident.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (tag_we) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = tag_wdata;
        end
    end

    // Next-state of the data words: single word write per cycle.
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            data_d[wr_idx][wr_word] = wr_data;
        end
    end

    // Valid bits clear asynchronously so a partial fill is never visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage, no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/c_dcache_stage.sv
// c_dcache_stage: memory (C) stage with a direct-mapped, write-through,
// no-write-allocate data cache and a blocking word-serial refill port.
// Optional feature macro DCACHE_STATS_EN adds stat_hits/stat_misses counters.
module c_dcache_stage
    import c_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        icache_stall,
    input  logic        mul_stall,
    input  logic [31:0] ac_pc,
    input  logic [4:0]  ac_write_sel,
    input  logic        ac_is_load,
    input  logic        ac_is_store,
    input  logic        ac_is_wb,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ac_data2,
    output logic [31:0] cw_pc,
    output logic        cw_is_wb,
    output logic [4:0]  cw_write_sel,
    output logic [31:0] cw_result,
    output logic        dcache_stall,
`ifdef DCACHE_STATS_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
`endif
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    dc_state_e        state_q, state_d;
    logic [OFF_W-1:0] refill_cnt_q, refill_cnt_d;
    logic             consumed_q, consumed_d;
    logic             store_done_q, store_done_d;

    logic [31:0]      cw_pc_q, cw_pc_d;
    logic             cw_is_wb_q, cw_is_wb_d;
    logic [4:0]       cw_write_sel_q, cw_write_sel_d;
    logic [31:0]      cw_result_q, cw_result_d;

    logic [OFF_W-1:0] a_word;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic             unused_addr_bits;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             do_load, do_store;
    logic             cw_adv;

    logic             wr_en;
    logic [OFF_W-1:0] wr_word;
    logic [31:0]      wr_data;
    logic             tag_we;

    assign a_word           = ALU_result[2 +: OFF_W];
    assign a_idx            = ALU_result[2 + OFF_W +: IDX_W];
    assign a_tag            = ALU_result[31 -: TAG_W];
    assign unused_addr_bits = ^ALU_result[1:0];

    // A replayed instruction that already retired is a bubble; a store whose
    // write finished while icache_stall held the C->W register is not reissued.
    assign do_store = ac_is_store && !consumed_q && !store_done_q;
    assign do_load  = ac_is_load && !ac_is_store && !consumed_q;
    assign hit      = rd_valid && (rd_tag == a_tag);
    assign cw_adv   = !dcache_stall && !icache_stall;

    dcache_array u_array (
        .clk       (clock),
        .rst_n     (reset),
        .rd_idx    (a_idx),
        .rd_word   (a_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (a_idx),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .tag_we    (tag_we),
        .tag_wdata (a_tag)
    );

    // FSM next-state, memory port, cache write port and stall generation.
    always_comb begin
        state_d      = state_q;
        refill_cnt_d = refill_cnt_q;
        dcache_stall = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        wr_en        = 1'b0;
        wr_word      = a_word;
        wr_data      = ac_data2;
        tag_we       = 1'b0;
        store_done_d = store_done_q;
        case (state_q)
            IDLE: begin
                if (do_store) begin
                    dcache_stall = 1'b1;
                    state_d      = WRITE;
                    wr_en        = hit;
                end else if (do_load && !hit) begin
                    dcache_stall = 1'b1;
                    state_d      = REFILL;
                    refill_cnt_d = '0;
                end
            end
            REFILL: begin
                dcache_stall = 1'b1;
                mem_req      = 1'b1;
                mem_addr     = {a_tag, a_idx, refill_cnt_q, 2'b00};
                if (mem_ack) begin
                    wr_en        = 1'b1;
                    wr_word      = refill_cnt_q;
                    wr_data      = mem_rdata;
                    refill_cnt_d = refill_cnt_q + 1'b1;
                    if (refill_cnt_q == '1) begin
                        tag_we  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = {ALU_result[31:2], 2'b00};
                mem_wdata    = ac_data2;
                dcache_stall = !mem_ack;
                if (mem_ack) begin
                    state_d = IDLE;
                    if (icache_stall) begin
                        store_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (cw_adv) begin
            store_done_d = 1'b0;
        end
    end

    // C->W register next-state and replay tracking.
    always_comb begin
        cw_pc_d        = cw_pc_q;
        cw_is_wb_d     = cw_is_wb_q;
        cw_write_sel_d = cw_write_sel_q;
        cw_result_d    = cw_result_q;
        consumed_d     = mul_stall && (consumed_q || cw_adv);
        if (cw_adv) begin
            cw_pc_d        = ac_pc;
            cw_write_sel_d = ac_write_sel;
            cw_is_wb_d     = ac_is_wb && !consumed_q;
            cw_result_d    = do_load ? rd_data : ALU_result;
        end
    end

    // State, refill counter, replay flags and C->W register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            refill_cnt_q   <= '0;
            consumed_q     <= 1'b0;
            store_done_q   <= 1'b0;
            cw_pc_q        <= '0;
            cw_is_wb_q     <= 1'b0;
            cw_write_sel_q <= '0;
            cw_result_q    <= '0;
        end else begin
            state_q        <= state_d;
            refill_cnt_q   <= refill_cnt_d;
            consumed_q     <= consumed_d;
            store_done_q   <= store_done_d;
            cw_pc_q        <= cw_pc_d;
            cw_is_wb_q     <= cw_is_wb_d;
            cw_write_sel_q <= cw_write_sel_d;
            cw_result_q    <= cw_result_d;
        end
    end

    assign cw_pc        = cw_pc_q;
    assign cw_is_wb     = cw_is_wb_q;
    assign cw_write_sel = cw_write_sel_q;
    assign cw_result    = cw_result_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;
    logic        refilled_q, refilled_d;

    // A load that needed a refill retires as a miss only, on its final hit lookup.
    always_comb begin
        hits_d     = hits_q;
        misses_d   = misses_q;
        refilled_d = refilled_q;
        if (tag_we) begin
            refilled_d = 1'b1;
        end
        if (cw_adv) begin
            refilled_d = 1'b0;
            if (do_load) begin
                if (refilled_q) begin
                    misses_d = misses_q + 32'd1;
                end else begin
                    hits_d = hits_q + 32'd1;
                end
            end
        end
    end

    // Statistics counters, wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hits_q     <= '0;
            misses_q   <= '0;
            refilled_q <= 1'b0;
        end else begin
            hits_q     <= hits_d;
            misses_q   <= misses_d;
            refilled_q <= refilled_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_c_dcache_stage.sv
// tb_c_dcache_stage: directed and random checks of c_dcache_stage against a
// line-residency reference model and a word-addressed memory model.
module tb_c_dcache_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        icache_stall = 1'b0;
    logic        mul_stall = 1'b0;
    logic [31:0] ac_pc = '0;
    logic [4:0]  ac_write_sel = '0;
    logic        ac_is_load = 1'b0;
    logic        ac_is_store = 1'b0;
    logic        ac_is_wb = 1'b0;
    logic [31:0] ALU_result = '0;
    logic [31:0] ac_data2 = '0;
    logic [31:0] cw_pc;
    logic        cw_is_wb;
    logic [4:0]  cw_write_sel;
    logic [31:0] cw_result;
    logic        dcache_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
    int          exp_hits = 0;
    int          exp_misses = 0;
`endif

    int total = 0;
    int bad = 0;
    int max_lat = 0;
    int lat = 0;

    logic [31:0] phys   [int unsigned];
    logic [31:0] refmem [int unsigned];
    int          res_line [16];
    logic [31:0] rlog [$];
    logic [31:0] wlog_a [$];
    logic [31:0] wlog_d [$];

    c_dcache_stage dut (
        .clock        (clock),
        .reset        (reset),
        .icache_stall (icache_stall),
        .mul_stall    (mul_stall),
        .ac_pc        (ac_pc),
        .ac_write_sel (ac_write_sel),
        .ac_is_load   (ac_is_load),
        .ac_is_store  (ac_is_store),
        .ac_is_wb     (ac_is_wb),
        .ALU_result   (ALU_result),
        .ac_data2     (ac_data2),
        .cw_pc        (cw_pc),
        .cw_is_wb     (cw_is_wb),
        .cw_write_sel (cw_write_sel),
        .cw_result    (cw_result),
        .dcache_stall (dcache_stall),
`ifdef DCACHE_STATS_EN
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses),
`endif
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_00AA;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        if (phys.exists(a >> 2)) return phys[a >> 2];
        return init_word({a[31:2], 2'b00});
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (refmem.exists(a >> 2)) return refmem[a >> 2];
        return init_word({a[31:2], 2'b00});
    endfunction

    // Memory responder: random latency, one-cycle ack per word.
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            mem_ack = 1'b0;
        end else if (mem_req && lat == 0) begin
            mem_ack = 1'b1;
            if (mem_we) begin
                phys[mem_addr >> 2] = mem_wdata;
                wlog_a.push_back(mem_addr);
                wlog_d.push_back(mem_wdata);
            end else begin
                mem_rdata = phys_rd(mem_addr);
                rlog.push_back(mem_addr);
            end
            lat = $urandom_range(0, max_lat);
        end else begin
            mem_ack = 1'b0;
            if (mem_req && lat > 0) lat--;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rlog.delete();
        wlog_a.delete();
        wlog_d.delete();
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) res_line[i] = -1;
`ifdef DCACHE_STATS_EN
        exp_hits = 0;
        exp_misses = 0;
`endif
    endtask

    // Called at a negedge with ac_* driven; returns at posedge+1 after retirement.
    task automatic wait_retire(output int stalls, input bit ric);
        bit ok;
        stalls = 0;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (ric) icache_stall = ($urandom_range(0, 3) == 0);
            #1;
            if (!dcache_stall && !icache_stall) begin
                ok = 1'b1;
                break;
            end
            if (dcache_stall) stalls++;
            @(negedge clock);
        end
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL retire_timeout observed=stalled expected=retired");
        end
        @(posedge clock);
        #1;
        icache_stall = 1'b0;
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store. exp_stall < 0 skips the stall-length check.
    task automatic op(input int kind, input logic [31:0] addr, input logic [31:0] data,
                      input logic wb, input int exp_stall, input bit ric, input logic mul);
        logic [31:0] pc;
        logic [4:0]  sel;
        logic [31:0] exp_res;
        logic [31:0] line_base;
        bit          miss;
        int          line;
        int          idx;
        int          st;
        @(negedge clock);
        clear_logs();
        pc  = $urandom;
        sel = 5'($urandom_range(0, 31));
        ac_pc        = pc;
        ac_write_sel = sel;
        ac_is_load   = (kind == 1);
        ac_is_store  = (kind == 2);
        ac_is_wb     = wb;
        ALU_result   = addr;
        ac_data2     = data;
        mul_stall    = mul;
        line      = int'(addr >> 4);
        idx       = line % 16;
        line_base = {addr[31:4], 4'h0};
        miss      = 1'b0;
        exp_res   = addr;
        if (kind == 1) begin
            miss = (res_line[idx] != line);
            res_line[idx] = line;
            exp_res = ref_rd(addr);
        end else if (kind == 2) begin
            refmem[addr >> 2] = data;
        end
        wait_retire(st, ric);
        check("cw_pc", cw_pc, pc);
        check("cw_write_sel", 32'(cw_write_sel), 32'(sel));
        check("cw_is_wb", 32'(cw_is_wb), 32'(wb));
        check("cw_result", cw_result, exp_res);
        check("rd_count", 32'(rlog.size()), miss ? 32'd4 : 32'd0);
        for (int i = 0; i < rlog.size() && i < 4; i++) begin
            check("rd_addr", rlog[i], line_base + 32'(i * 4));
        end
        check("wr_count", 32'(wlog_a.size()), (kind == 2) ? 32'd1 : 32'd0);
        if (wlog_a.size() > 0) begin
            check("wr_addr", wlog_a[0], {addr[31:2], 2'b00});
            check("wr_data", wlog_d[0], data);
        end
        if (exp_stall >= 0) check("stall_cycles", 32'(st), 32'(exp_stall));
`ifdef DCACHE_STATS_EN
        if (kind == 1) begin
            if (miss) exp_misses++;
            else exp_hits++;
        end
        check("stat_hits", stat_hits, 32'(exp_hits));
        check("stat_misses", stat_misses, 32'(exp_misses));
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        reset_model();
        #22;
        check("rst_cw_pc", cw_pc, 32'h0);
        check("rst_cw_is_wb", 32'(cw_is_wb), 32'h0);
        check("rst_cw_sel", 32'(cw_write_sel), 32'h0);
        check("rst_cw_result", cw_result, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_stall", 32'(dcache_stall), 32'h0);
`ifdef DCACHE_STATS_EN
        check("rst_stat_hits", stat_hits, 32'h0);
        check("rst_stat_misses", stat_misses, 32'h0);
`endif
        @(negedge clock);
        reset = 1'b1;

        // Directed sequence, zero-latency memory.
        max_lat = 0;
        op(1, 32'h100, 32'h0, 1'b1, 5, 1'b0, 1'b0);
        op(1, 32'h104, 32'h0, 1'b1, 0, 1'b0, 1'b0);
        op(2, 32'h108, 32'h55, 1'b0, 1, 1'b0, 1'b0);
        op(1, 32'h108, 32'h0, 1'b1, 0, 1'b0, 1'b0);
        op(2, 32'h2000, 32'hDEAD_BEEF, 1'b0, 1, 1'b0, 1'b0);
        op(1, 32'h2000, 32'h0, 1'b1, 5, 1'b0, 1'b0);
        op(0, 32'h1234_5678, 32'h0, 1'b1, 0, 1'b0, 1'b0);

        // Store held by mul_stall: retires once, then replays are bubbles.
        op(2, 32'h10C, 32'h77, 1'b1, 1, 1'b0, 1'b1);
        for (int r = 0; r < 2; r++) begin
            @(negedge clock);
            #1;
            check("replay_stall", 32'(dcache_stall), 32'h0);
            @(posedge clock);
            #1;
            check("replay_cw_is_wb", 32'(cw_is_wb), 32'h0);
        end
        check("replay_wr_count", 32'(wlog_a.size()), 32'd1);
        @(negedge clock);
        mul_stall = 1'b0;

        // Reset in the middle of a refill.
        @(negedge clock);
        clear_logs();
        ac_is_load  = 1'b1;
        ac_is_store = 1'b0;
        ac_is_wb    = 1'b1;
        ALU_result  = 32'h300;
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clock);
            #1;
            if (rlog.size() >= 2) begin
                got = 1'b1;
                break;
            end
        end
        check("midfill_acks_seen", 32'(got), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("midfill_mem_req", 32'(mem_req), 32'h0);
        check("midfill_cw_is_wb", 32'(cw_is_wb), 32'h0);
        check("midfill_cw_result", cw_result, 32'h0);
        ac_is_load = 1'b0;
        ac_is_wb   = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        reset_model();
        op(1, 32'h304, 32'h0, 1'b1, 5, 1'b0, 1'b0);
        op(1, 32'h100, 32'h0, 1'b1, 5, 1'b0, 1'b0);

        // Random traffic with memory latency and fetch stalls.
        max_lat = 2;
        for (int k = 0; k < 200; k++) begin
            int          sel;
            int          kind;
            logic [31:0] a;
            sel  = $urandom_range(0, 3);
            kind = (sel == 0) ? 0 : ((sel == 3) ? 2 : 1);
            a    = ($urandom_range(0, 1) != 0 ? 32'h1000 : 32'h0)
                 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            op(kind, a, $urandom, 1'($urandom_range(0, 1)), -1, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
